// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor
//   Bridges a 256-bit line interface (upstream eviction write buffer) to a
//   4-beat x 64-bit burst interface (physical DRAM). One transaction is in
//   flight at a time; beats go little-end first (beat 0 = bits 63:0).
//
// Ports
//   clk, rst        : clock, asynchronous active-high reset
//   pmem_read       : line read request, held until pmem_resp
//   pmem_write      : line write request, held until pmem_resp
//   pmem_address    : line address, bits [4:0] ignored
//   pmem_wdata      : line to write, sampled when the request is accepted
//   pmem_rdata      : last assembled read line (not touched by writes)
//   pmem_resp       : one-cycle completion pulse
//   burst_read      : read burst active
//   burst_write     : write burst active
//   burst_address   : aligned captured address, 0 outside a burst
//   burst_wdata     : current write beat, 0 outside a write burst
//   burst_rdata     : incoming read beat, valid with burst_resp
//   burst_resp      : one beat transferred this cycle
//
// All outputs come straight from flops, so reset clears them immediately.

module cacheline_adaptor (
  input  logic         clk,
  input  logic         rst,
  input  logic         pmem_read,
  input  logic         pmem_write,
  input  logic [31:0]  pmem_address,
  input  logic [255:0] pmem_wdata,
  output logic [255:0] pmem_rdata,
  output logic         pmem_resp,
  output logic         burst_read,
  output logic         burst_write,
  output logic [31:0]  burst_address,
  output logic [63:0]  burst_wdata,
  input  logic [63:0]  burst_rdata,
  input  logic         burst_resp
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t         state_r, state_nxt_s;
  logic [1:0]     cnt_r, cnt_nxt_s, cnt_inc_s;
  logic [255:0]   rline_r, rline_nxt_s;
  logic [255:0]   wline_r, wline_nxt_s;
  logic [31:0]    addr_r, addr_nxt_s;
  logic [63:0]    wdata_r, wdata_nxt_s;
  logic           rd_r, rd_nxt_s;
  logic           wr_r, wr_nxt_s;
  logic           resp_r, resp_nxt_s;

  // 2-bit increment wraps 3 -> 0, which leaves the counter clean for DONE.
  assign cnt_inc_s = cnt_r + 2'd1;

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= 2'd0;
      rline_r <= 256'd0;
      wline_r <= 256'd0;
      addr_r  <= 32'd0;
      wdata_r <= 64'd0;
      rd_r    <= 1'b0;
      wr_r    <= 1'b0;
      resp_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      rline_r <= rline_nxt_s;
      wline_r <= wline_nxt_s;
      addr_r  <= addr_nxt_s;
      wdata_r <= wdata_nxt_s;
      rd_r    <= rd_nxt_s;
      wr_r    <= wr_nxt_s;
      resp_r  <= resp_nxt_s;
    end
  end

  // Next-state logic; output registers are loaded with the values they must
  // show in the state being entered.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    rline_nxt_s = rline_r;
    wline_nxt_s = wline_r;
    addr_nxt_s  = 32'd0;
    wdata_nxt_s = 64'd0;
    rd_nxt_s    = 1'b0;
    wr_nxt_s    = 1'b0;
    resp_nxt_s  = 1'b0;

    case (state_r)
      IDLE: begin
        cnt_nxt_s = 2'd0;
        // Read has priority if both requests are present.
        if (pmem_read) begin
          state_nxt_s = READ;
          addr_nxt_s  = {pmem_address[31:5], 5'd0};
          rd_nxt_s    = 1'b1;
        end else if (pmem_write) begin
          state_nxt_s = WRITE;
          addr_nxt_s  = {pmem_address[31:5], 5'd0};
          wline_nxt_s = pmem_wdata;
          wdata_nxt_s = pmem_wdata[63:0];
          wr_nxt_s    = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end

      READ: begin
        addr_nxt_s = addr_r;
        rd_nxt_s   = 1'b1;
        if (burst_resp) begin
          rline_nxt_s[{cnt_r, 6'd0} +: 64] = burst_rdata;
          cnt_nxt_s = cnt_inc_s;
          if (cnt_r == 2'd3) begin
            state_nxt_s = DONE;
            addr_nxt_s  = 32'd0;
            rd_nxt_s    = 1'b0;
            resp_nxt_s  = 1'b1;
          end else begin
            state_nxt_s = READ;
          end
        end else begin
          state_nxt_s = READ;
        end
      end

      WRITE: begin
        addr_nxt_s  = addr_r;
        wr_nxt_s    = 1'b1;
        wdata_nxt_s = wline_r[{cnt_r, 6'd0} +: 64];
        if (burst_resp) begin
          cnt_nxt_s = cnt_inc_s;
          if (cnt_r == 2'd3) begin
            state_nxt_s = DONE;
            addr_nxt_s  = 32'd0;
            wr_nxt_s    = 1'b0;
            wdata_nxt_s = 64'd0;
            resp_nxt_s  = 1'b1;
          end else begin
            // Next beat must be on the bus in the following cycle.
            state_nxt_s = WRITE;
            wdata_nxt_s = wline_r[{cnt_inc_s, 6'd0} +: 64];
          end
        end else begin
          state_nxt_s = WRITE;
        end
      end

      DONE: begin
        state_nxt_s = IDLE;
      end

      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = 2'd0;
      end
    endcase
  end

  assign pmem_rdata    = rline_r;
  assign pmem_resp     = resp_r;
  assign burst_read    = rd_r;
  assign burst_write   = wr_r;
  assign burst_address = addr_r;
  assign burst_wdata   = wdata_r;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Self-checking bench for cacheline_adaptor. A transaction-level model
// predicts, per cycle, the strobes, address, write beat, completion cycle
// (5 + number of gap cycles) and the read line.

module tb_cacheline_adaptor;

  logic         clk = 1'b0;
  logic         rst;
  logic         pmem_read, pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;
  logic         burst_read, burst_write;
  logic [31:0]  burst_address;
  logic [63:0]  burst_wdata;
  logic [63:0]  burst_rdata;
  logic         burst_resp;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int fail_cnt = 0;
  logic [255:0] exp_rdata;

  cacheline_adaptor dut (
    .clk          (clk),
    .rst          (rst),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp),
    .burst_read   (burst_read),
    .burst_write  (burst_write),
    .burst_address(burst_address),
    .burst_wdata  (burst_wdata),
    .burst_rdata  (burst_rdata),
    .burst_resp   (burst_resp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Outputs expected while nothing is in flight.
  task automatic chk_quiet(input string tag);
    chk({tag, " resp"},  256'(pmem_resp), 256'(0));
    chk({tag, " rd"},    256'(burst_read), 256'(0));
    chk({tag, " wr"},    256'(burst_write), 256'(0));
    chk({tag, " addr"},  256'(burst_address), 256'(0));
    chk({tag, " wdata"}, 256'(burst_wdata), 256'(0));
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  // Idle cycles with random stray burst_resp pulses.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk_quiet("idle");
      chk("idle rdata", pmem_rdata, exp_rdata);
      burst_resp  = 1'($urandom_range(0, 1));
      burst_rdata = {$urandom, $urandom};
    end
    burst_resp = 1'b0;
  endtask

  // One transaction. Called at a negedge just before the DUT's IDLE cycle;
  // gaps[b] = idle burst cycles before beat b.
  task automatic txn(input bit rd, input bit wr, input logic [31:0] addr,
                     input logic [255:0] line, input int gaps[4]);
    int cyc;
    int total;
    logic [31:0] exp_addr;
    bit is_rd;
    is_rd    = rd;
    exp_addr = addr & 32'hFFFF_FFE0;
    total    = 0;
    cyc      = 0;
    @(negedge clk);
    chk_quiet("accept");
    pmem_read    = rd;
    pmem_write   = wr;
    pmem_address = addr;
    pmem_wdata   = line;
    burst_resp   = 1'b0;
    for (int b = 0; b < 4; b++) begin
      for (int g = 0; g <= gaps[b]; g++) begin
        @(negedge clk);
        cyc++;
        chk("burst_read",  256'(burst_read), 256'(is_rd));
        chk("burst_write", 256'(burst_write), 256'(!is_rd));
        chk("burst_addr",  256'(burst_address), 256'(exp_addr));
        chk("early resp",  256'(pmem_resp), 256'(0));
        if (!is_rd) chk("burst_wdata", 256'(burst_wdata), 256'(line[b*64 +: 64]));
        // Upstream wiggles that must be ignored mid-burst.
        pmem_address = $urandom;
        pmem_wdata   = rand_line();
        burst_resp   = (g == gaps[b]);
        burst_rdata  = (g == gaps[b]) ? line[b*64 +: 64] : {$urandom, $urandom};
      end
      total += gaps[b];
    end
    @(negedge clk);
    cyc++;
    chk("pmem_resp", 256'(pmem_resp), 256'(1));
    chk("latency",   256'(cyc), 256'(5 + total));
    chk("done rd",   256'(burst_read), 256'(0));
    chk("done wr",   256'(burst_write), 256'(0));
    chk("done addr", 256'(burst_address), 256'(0));
    if (is_rd) exp_rdata = line;
    chk("pmem_rdata", pmem_rdata, exp_rdata);
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    burst_resp = 1'b0;
  endtask

  initial begin
    int gz[4];
    int gw[4];
    int gr[4];
    logic [255:0] l;
    gz = '{0, 0, 0, 0};
    gw = '{0, 1, 2, 0};
    rst          = 1'b1;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = 32'd0;
    pmem_wdata   = 256'd0;
    burst_rdata  = 64'd0;
    burst_resp   = 1'b0;
    exp_rdata    = 256'd0;
    repeat (2) @(negedge clk);
    chk_quiet("reset");
    chk("reset rdata", pmem_rdata, 256'd0);
    rst = 1'b0;

    idle(3);

    // Directed read, consecutive beats.
    l = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
    txn(1'b1, 1'b0, 32'h0000_1234, l, gz);

    // Directed write with gap pattern 1,0,1,0,0,1,1 (latency 8).
    l = {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};
    txn(1'b0, 1'b1, 32'h0000_8040, l, gw);

    // Back-to-back read right after the write.
    txn(1'b1, 1'b0, $urandom, rand_line(), gz);

    // Both requests: read wins.
    txn(1'b1, 1'b1, $urandom, rand_line(), gz);

    idle(4);

    // Reset mid-read after two beats.
    @(negedge clk);
    pmem_read    = 1'b1;
    pmem_address = 32'h0000_4000;
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      burst_resp  = 1'b1;
      burst_rdata = {$urandom, $urandom};
    end
    @(negedge clk);
    burst_resp = 1'b0;
    chk("pre-reset rd", 256'(burst_read), 256'(1));
    #2 rst = 1'b1;
    #1;
    chk_quiet("async rst");
    chk("async rst rdata", pmem_rdata, 256'd0);
    exp_rdata  = 256'd0;
    pmem_read  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    txn(1'b1, 1'b0, 32'h0000_4000, rand_line(), gz);

    // Randomized transactions with random gaps.
    for (int t = 0; t < 12; t++) begin
      bit rd;
      rd = 1'($urandom_range(0, 1));
      for (int b = 0; b < 4; b++) gr[b] = $urandom_range(0, 2);
      txn(rd, !rd, $urandom, rand_line(), gr);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
